// File: rtl/v68k_bus_pkg.sv
// Shared types and constants for the V68k 68000-style bus interface unit.
// Strobes are active-low on the pins; the constants below name pin levels.
package v68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S0   = 3'd1,
        ST_S2   = 3'd2,
        ST_S4   = 3'd3,
        ST_WAIT = 3'd4,
        ST_S6   = 3'd5,
        ST_S7   = 3'd6
    } bus_state_e;

    localparam logic DS_ON     = 1'b0;
    localparam logic DS_OFF    = 1'b1;
    localparam logic AS_STROBE = 1'b0;
    localparam logic AS_OFF    = 1'b1;
    localparam logic RW_READ   = 1'b1;
    localparam logic RW_WRITE  = 1'b0;

    localparam int unsigned TIMEOUT_DEFAULT = 64;

    typedef struct packed {
        logic [22:0] addr;
        logic        rw;
        logic        uds;
        logic        lds;
        logic [2:0]  fc;
        logic [15:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/v68k_sync2.sv
// Two-flop synchronizer for asynchronous active-low bus inputs; resets to the
// negated level (1) so a freshly reset controller never sees a phantom DTACK/BERR.
module v68k_sync2 (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/v68k_bus_controller.sv
// Runs one asynchronous 68000 bus cycle per core request (S0..S7 with DTACK/BERR
// wait states and a DTACK timeout). All bus pins are registered from the next state.
module v68k_bus_controller
    import v68k_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req,
    input  logic [22:0] req_addr,
    input  logic        req_rw,
    input  logic        req_uds,
    input  logic        req_lds,
    input  logic [2:0]  req_fc,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic [22:0] A,
    output logic [2:0]  FC,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic        RW,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    input  logic [15:0] D_IN,
    input  logic        DTACK,
    input  logic        BERR
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic dtack_s, berr_s;

    v68k_sync2 u_sync_dtack (.CLK(CLK), .RESET(RESET), .d(DTACK), .q(dtack_s));
    v68k_sync2 u_sync_berr  (.CLK(CLK), .RESET(RESET), .d(BERR),  .q(berr_s));

    bus_state_e  state_q, state_d;
    bus_req_t    req_q, req_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        term_err;
    logic        is_wr;

    logic [22:0] a_q, a_d;
    logic [2:0]  fc_q, fc_d;
    logic        as_q, as_d;
    logic        uds_q, uds_d;
    logic        lds_q, lds_d;
    logic        rw_q, rw_d;
    logic [15:0] dout_q, dout_d;
    logic        doe_q, doe_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;

    // Next-state: req is only looked at in IDLE; WAIT priority is BERR, DTACK, timeout.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        cnt_d    = '0;
        term_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    req_d.addr  = req_addr;
                    req_d.rw    = req_rw;
                    req_d.uds   = req_uds;
                    req_d.lds   = req_lds;
                    req_d.fc    = req_fc;
                    req_d.wdata = req_wdata;
                    state_d     = ST_S0;
                end
            end
            ST_S0:   state_d = ST_S2;
            ST_S2:   state_d = ST_S4;
            ST_S4:   state_d = ST_WAIT;
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (!berr_s) begin
                    state_d  = ST_S7;
                    term_err = 1'b1;
                end else if (!dtack_s) begin
                    state_d = ST_S6;
                end else if (cnt_q == TO_LAST) begin
                    state_d  = ST_S7;
                    term_err = 1'b1;
                end
            end
            ST_S6:   state_d = ST_S7;
            ST_S7:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin levels are decoded from the state being entered so they change on the edge.
    always_comb begin
        a_d    = a_q;
        fc_d   = fc_q;
        dout_d = dout_q;
        as_d   = AS_OFF;
        uds_d  = DS_OFF;
        lds_d  = DS_OFF;
        rw_d   = RW_READ;
        doe_d  = 1'b0;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        is_wr  = (req_d.rw == RW_WRITE);
        case (state_d)
            ST_S0: begin
                a_d  = req_d.addr;
                fc_d = req_d.fc;
                rw_d = req_d.rw;
            end
            ST_S2: begin
                rw_d = req_d.rw;
                as_d = AS_STROBE;
                if (is_wr) begin
                    dout_d = req_d.wdata;
                    doe_d  = 1'b1;
                end else begin
                    uds_d = req_d.uds ? DS_ON : DS_OFF;
                    lds_d = req_d.lds ? DS_ON : DS_OFF;
                end
            end
            ST_S4, ST_WAIT, ST_S6: begin
                rw_d  = req_d.rw;
                as_d  = AS_STROBE;
                uds_d = req_d.uds ? DS_ON : DS_OFF;
                lds_d = req_d.lds ? DS_ON : DS_OFF;
                doe_d = is_wr;
            end
            ST_S7: begin
                rw_d  = req_d.rw;
                doe_d = is_wr;
                ack_d = 1'b1;
                err_d = term_err;
            end
            default: ;
        endcase
        rdata_d = (state_q == ST_S6 && req_q.rw == RW_READ) ? D_IN : rdata_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            fc_q    <= '0;
            as_q    <= AS_OFF;
            uds_q   <= DS_OFF;
            lds_q   <= DS_OFF;
            rw_q    <= RW_READ;
            dout_q  <= '0;
            doe_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            fc_q    <= fc_d;
            as_q    <= as_d;
            uds_q   <= uds_d;
            lds_q   <= lds_d;
            rw_q    <= rw_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign A     = a_q;
    assign FC    = fc_q;
    assign AS    = as_q;
    assign UDS   = uds_q;
    assign LDS   = lds_q;
    assign RW    = rw_q;
    assign D_OUT = dout_q;
    assign D_OE  = doe_q;

endmodule

// File: tb/tb_v68k_bus_controller.sv
// Randomized bench for v68k_bus_controller against a cycle-count model of the bus cycle.
module tb_v68k_bus_controller;

    localparam int TO = 8;
    localparam int NEVER = 1000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req;
    logic [22:0] req_addr;
    logic        req_rw, req_uds, req_lds;
    logic [2:0]  req_fc;
    logic [15:0] req_wdata;
    logic        busy, ack, err;
    logic [15:0] rdata;
    logic [22:0] A;
    logic [2:0]  FC;
    logic        AS, UDS, LDS, RW;
    logic [15:0] D_OUT;
    logic        D_OE;
    logic [15:0] D_IN;
    logic        DTACK, BERR;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] model_rdata;

    always #5 CLK = ~CLK;

    v68k_bus_controller #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_uds(req_uds), .req_lds(req_lds), .req_fc(req_fc), .req_wdata(req_wdata),
        .busy(busy), .ack(ack), .err(err), .rdata(rdata), .A(A), .FC(FC), .AS(AS),
        .UDS(UDS), .LDS(LDS), .RW(RW), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
        .DTACK(DTACK), .BERR(BERR)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".ack"}, ack, 0);
        chk({tag, ".AS"}, AS, 1);
        chk({tag, ".UDS"}, UDS, 1);
        chk({tag, ".LDS"}, LDS, 1);
        chk({tag, ".RW"}, RW, 1);
        chk({tag, ".D_OE"}, D_OE, 0);
        chk({tag, ".rdata"}, rdata, model_rdata);
    endtask

    // Called at a falling edge with the DUT idle. Edge 0 is the accept edge.
    // Raw DTACK/BERR are low for edges >= dk / bk. The synchronizer means the
    // decision leaving the t-th WAIT cycle sees the raw level sampled at edge t+1.
    task automatic run_txn(input logic rw, input logic [22:0] addr, input logic uds,
                           input logic lds, input logic [2:0] fc, input logic [15:0] wd,
                           input logic [15:0] din, input int dk, input int bk,
                           input bit hold, input int rst_at);
        int  e;
        bit  er;
        bit  ds_on;
        e  = 0;
        er = 0;
        for (int t = 1; t <= TO; t++) begin
            if (t + 1 >= bk) begin e = 3 + t; er = 1; break; end
            if (t + 1 >= dk) begin e = 4 + t; er = 0; break; end
            if (t == TO) begin e = 3 + t; er = 1; end
        end
        req = 1; req_rw = rw; req_addr = addr; req_uds = uds; req_lds = lds;
        req_fc = fc; req_wdata = wd; D_IN = din;
        DTACK = (0 >= dk) ? 1'b0 : 1'b1;
        BERR  = (0 >= bk) ? 1'b0 : 1'b1;
        for (int r = 0; r <= e + 1; r++) begin
            @(negedge CLK);
            if (r <= e) begin
                if (r == e && rw && !er) model_rdata = din;
                chk("busy", busy, 1);
                chk("ack", ack, (r == e));
                chk("A", A, addr);
                chk("FC", FC, fc);
                chk("RW", RW, rw);
                chk("AS", AS, (r >= 1 && r < e) ? 0 : 1);
                ds_on = rw ? (r >= 1 && r < e) : (r >= 2 && r < e);
                chk("UDS", UDS, !(ds_on && uds));
                chk("LDS", LDS, !(ds_on && lds));
                chk("D_OE", D_OE, (!rw && r >= 1));
                if (!rw && r >= 1) chk("D_OUT", D_OUT, wd);
                if (r == e) chk("err", err, er);
                chk("rdata", rdata, model_rdata);
            end else begin
                chk_idle("gap");
            end
            if (r == rst_at) begin
                req = 0; RESET = 1; DTACK = 1; BERR = 1;
                @(negedge CLK);
                model_rdata = '0;
                chk_idle("rst");
                chk("rst.A", A, 0);
                chk("rst.D_OUT", D_OUT, 0);
                RESET = 0;
                repeat (3) begin
                    @(negedge CLK);
                    chk("rst.noack", ack, 0);
                end
                return;
            end
            if (!hold) req = 0;
            DTACK = (r + 1 <= e && r + 1 >= dk) ? 1'b0 : 1'b1;
            BERR  = (r + 1 <= e && r + 1 >= bk) ? 1'b0 : 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   h;
        int   dk, bk, gap;
        model_rdata = '0;
        RESET = 1; req = 0; req_addr = '0; req_rw = 1; req_uds = 0; req_lds = 0;
        req_fc = '0; req_wdata = '0; D_IN = '0; DTACK = 1; BERR = 1;
        repeat (3) @(negedge CLK);
        chk_idle("reset");
        chk("reset.A", A, 0);
        chk("reset.FC", FC, 0);
        chk("reset.D_OUT", D_OUT, 0);
        chk("reset.err", err, 0);
        RESET = 0;
        @(negedge CLK);

        // word read, DTACK already low: ack 5 edges after accept
        run_txn(1, 23'h000010, 1, 1, 3'b110, 16'h0000, 16'h4E71, -100, NEVER, 0, -1);
        // low-byte write, DTACK three cycles late: ack after 8
        run_txn(0, 23'h001234, 0, 1, 3'b101, 16'h00A5, 16'hFFFF, 5, NEVER, 0, -1);
        // timeout with no DTACK
        run_txn(1, 23'h7FFFFF, 1, 1, 3'b010, 16'h0000, 16'hDEAD, NEVER, NEVER, 0, -1);
        // BERR and DTACK together
        run_txn(1, 23'h000100, 1, 0, 3'b001, 16'h0000, 16'hBEEF, 3, 3, 0, -1);
        // no selects, ends by DTACK
        run_txn(1, 23'h000200, 0, 0, 3'b110, 16'h0000, 16'h1111, 4, NEVER, 0, -1);
        // req held across ack: one IDLE cycle between reads
        run_txn(1, 23'h000300, 1, 1, 3'b110, 16'h0000, 16'hA5A5, -1, NEVER, 1, -1);
        run_txn(1, 23'h000302, 1, 1, 3'b110, 16'h0000, 16'h5A5A, 2, NEVER, 0, -1);
        // reset while waiting
        run_txn(0, 23'h000400, 1, 1, 3'b101, 16'hC3C3, 16'h0000, NEVER, NEVER, 0, 5);

        for (int k = 0; k < 40; k++) begin
            h  = ($urandom_range(0, 3) == 0) && (k != 39);
            dk = int'($urandom_range(0, 14)) - 2;
            bk = ($urandom_range(0, 1) == 0) ? NEVER : int'($urandom_range(2, 12));
            run_txn(1'($urandom_range(0, 1)), 23'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom), 16'($urandom),
                    dk, bk, h, -1);
            if (!h) begin
                gap = int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++) begin
                    @(negedge CLK);
                    chk_idle("idle");
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
